irb_frame_sink: RTL and testbench

- Sits directly downstream of the LCD controller and consumes its image-result-buffer (IRB) write port.
- Captures the 64-byte 8x8 processed frame into local storage while keeping a running checksum and an address-sequence check.
- After the controller asserts done, replays the frame in address order on a valid/ready byte stream for the next stage (display/DMA/checker).

---
 rtl/irb_frame_sink.sv | 115 +++++++++++
 tb/tb_irb_frame_sink.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/irb_frame_sink.sv
// irb_frame_sink: captures the 8x8 frame written by the LCD controller on its
// IRB write port. It keeps a running checksum and an address-sequence check,
// and replays the frame in address order on a valid/ready byte stream once
// the controller signals done.
module irb_frame_sink #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          irb_rw,
    input  logic [AW-1:0] irb_a,
    input  logic [DW-1:0] irb_d,
    input  logic          lcd_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [15:0]   checksum,
    output logic          seq_err,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        CAPTURE,
        WAIT_DONE,
        STREAM,
        FINISH
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic [AW:0]   rd_idx;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;
    logic          last_wr;

    // Writes are only accepted while capturing; the controller keeps irb_rw low afterwards.
    assign wr_en   = (state == CAPTURE) && !irb_rw;
    assign last_wr = wr_en && (wr_cnt == AW'(DEPTH - 1));

    // Frame storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[irb_a] <= irb_d;
        end
    end

    // Control FSM with registered stream outputs, checksum and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CAPTURE;
            wr_cnt     <= '0;
            rd_idx     <= '0;
            checksum   <= '0;
            seq_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (wr_en) begin
                        checksum <= checksum + 16'(irb_d);
                        wr_cnt   <= wr_cnt + 1'b1;
                        if (irb_a != wr_cnt) begin
                            seq_err <= 1'b1;
                        end
                        if (last_wr) begin
                            state <= WAIT_DONE;
                        end
                    end
                    // done together with the 64th write is left for WAIT_DONE to see next cycle
                    if (lcd_done && !last_wr) begin
                        seq_err    <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= FINISH;
                    end
                end
                WAIT_DONE: begin
                    if (lcd_done) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[0];
                        out_last  <= 1'b0;
                        rd_idx    <= (AW+1)'(1);
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (!out_last) begin
                            out_data <= mem[rd_idx[AW-1:0]];
                            out_last <= (rd_idx == (AW+1)'(DEPTH - 1));
                            rd_idx   <= rd_idx + 1'b1;
                        end else begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    state <= FINISH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irb_frame_sink.sv
// Testbench for irb_frame_sink: randomized frames checked by a scoreboard
// fed from a behavioural frame model.
module tb_irb_frame_sink;

    logic       clk = 1'b0;
    logic       reset;
    logic       irb_rw;
    logic [5:0] irb_a;
    logic [7:0] irb_d;
    logic       lcd_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [15:0] checksum;
    logic       seq_err;
    logic       frame_done;

    irb_frame_sink #(.DEPTH(64), .AW(6), .DW(8)) dut (
        .clk(clk), .reset(reset), .irb_rw(irb_rw), .irb_a(irb_a), .irb_d(irb_d),
        .lcd_done(lcd_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .checksum(checksum),
        .seq_err(seq_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    beat_cnt    = 0;
    int    ready_mode  = 0;

    // Reference model: frame contents plus capture bookkeeping.
    logic [7:0] ref_mem [64];
    int         ref_cnt;
    int         ref_sum;
    bit         ref_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        ref_cnt = 0;
        ref_sum = 0;
        ref_err = 0;
    endtask

    // One capture-cycle write; the model only counts writes while the frame is incomplete.
    task automatic wr(input int addr, input int data);
        irb_rw = 1'b0;
        irb_a  = 6'(addr);
        irb_d  = 8'(data);
        tick();
        if (ref_cnt < 64) begin
            ref_mem[addr] = 8'(data);
            ref_sum       = (ref_sum + data) % 65536;
            if (addr != ref_cnt) ref_err = 1;
            ref_cnt++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        irb_rw    = 1'b1;
        lcd_done  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        beat_cnt = 0;
        model_clear();
    endtask

    // Issue done, queue the expected stream and wait for the frame to finish.
    task automatic stream_frame(input bit check_rate);
        int cycles;
        for (int i = 0; i < 64; i++) exp_q.push_back({(i == 63), ref_mem[i]});
        chk("checksum", 32'(checksum), 32'(ref_sum));
        chk("seq_err", 32'(seq_err), 32'(ref_err));
        lcd_done = 1'b1;
        chk("valid_before_done", 32'(out_valid), 0);
        tick();
        chk("done_to_valid_latency", 32'(out_valid), 1);
        lcd_done = 1'b0;
        cycles = 0;
        while (!frame_done && cycles < 1000) begin
            tick();
            cycles++;
        end
        chk("stream_timeout", 32'(frame_done), 1);
        if (check_rate) chk("back_to_back_cycles", 32'(cycles), 64);
        chk("all_beats_seen", 32'(exp_q.size()), 0);
        chk("valid_after_finish", 32'(out_valid), 0);
        chk("checksum_hold", 32'(checksum), 32'(ref_sum));
    endtask

    // Downstream ready pattern generator.
    int rphase = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        rphase++;
    end

    // Scoreboard monitor: every presented byte must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got data %0h with empty queue", out_data);
            end else begin
                chk("stream_byte", {23'd0, out_last, out_data}, {23'd0, exp_q[0].last, exp_q[0].data});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beat_cnt++;
                end
            end
        end
    end

    initial begin
        int t;
        out_ready = 1'b1;
        irb_a     = '0;
        irb_d     = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        do_reset();
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_data", 32'(out_data), 0);
        chk("reset_last", 32'(out_last), 0);
        chk("reset_checksum", 32'(checksum), 0);
        chk("reset_seq_err", 32'(seq_err), 0);
        chk("reset_frame_done", 32'(frame_done), 0);

        // 1: in-order frame, data = address, ready held high
        ready_mode = 0;
        for (int i = 0; i < 64; i++) wr(i, i);
        irb_rw = 1'b1;
        chk("t1_checksum_const", 32'(checksum), 32'h07E0);
        stream_frame(1);
        chk("t1_seq_err", 32'(seq_err), 0);

        // 2: random data, stalling ready pattern
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 64; i++) wr(i, int'($urandom_range(0, 255)));
        irb_rw = 1'b1;
        stream_frame(0);

        // 3: misordered write at index 4 (address 5, 0xAA), random ready
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 64; i++) begin
            if (i == 4) wr(5, 8'hAA);
            else wr(i, int'($urandom_range(0, 255)));
        end
        irb_rw = 1'b1;
        chk("t3_seq_err_model", 32'(ref_err), 1);
        stream_frame(0);

        // 4: premature done after 10 writes
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 10; i++) wr(i, int'($urandom_range(0, 255)));
        irb_rw   = 1'b1;
        lcd_done = 1'b1;
        tick();
        chk("t4_seq_err", 32'(seq_err), 1);
        chk("t4_frame_done", 32'(frame_done), 1);
        chk("t4_valid", 32'(out_valid), 0);
        for (int i = 0; i < 10; i++) tick();
        lcd_done = 1'b0;
        chk("t4_checksum", 32'(checksum), 32'(ref_sum));

        // 5: controller keeps writing after the frame; must be ignored
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 64; i++) wr(i, int'($urandom_range(0, 254)));
        for (int i = 0; i < 20; i++) wr(63, 8'hFF);
        stream_frame(0);
        irb_rw = 1'b1;

        // 6: reset in the middle of streaming, then a fresh frame
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 64; i++) wr(i, int'($urandom_range(0, 255)));
        irb_rw = 1'b1;
        for (int i = 0; i < 64; i++) exp_q.push_back({(i == 63), ref_mem[i]});
        lcd_done = 1'b1;
        t = 0;
        while (beat_cnt < 20 && t < 200) begin
            tick();
            t++;
        end
        chk("t6_beats_before_reset", 32'(beat_cnt), 20);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_data", 32'(out_data), 0);
        chk("t6_async_last", 32'(out_last), 0);
        chk("t6_async_checksum", 32'(checksum), 0);
        chk("t6_async_frame_done", 32'(frame_done), 0);
        lcd_done = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 64; i++) wr(i, 8'h80);
        irb_rw = 1'b1;
        chk("t6_checksum_const", 32'(checksum), 32'h2000);
        stream_frame(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
